// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT_HI = 2'd0,
        BOOT_LO = 2'd1,
        RUN     = 2'd2,
        HALTED  = 2'd3
    } fetch_state_t;

    localparam logic [4:0]  HLT_OPCODE_DEF    = 5'b00001;
    localparam logic [15:0] NOP_WORD_DEF      = 16'h0000;
    localparam int          RESET_VEC_ADDR_HI = 0;
    localparam int          RESET_VEC_ADDR_LO = 1;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with load (priority), increment and hold.
module pc_reg #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_val_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_val_reg <= '0;
        end else if (load) begin
            pc_val_reg <= load_val;
        end else if (inc) begin
            pc_val_reg <= pc_val_reg + 1'b1;
        end
    end

    assign pc = pc_val_reg;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: boots PC from a two-word reset vector, then issues one
// registered instruction word per cycle with stall, redirect and halt.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          PC_W       = 32,
    parameter int          IMEM_AW    = 20,
    parameter logic [4:0]  HLT_OPCODE = HLT_OPCODE_DEF,
    parameter logic [15:0] NOP_WORD   = NOP_WORD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [15:0]        imem_data,
    input  logic               stall,
    input  logic               jump_bit,
    input  logic [PC_W-1:0]    jump_target,
    output logic [15:0]        ir_out,
    output logic               ir_valid,
    output logic [PC_W-1:0]    pc_out,
    output logic               flush,
    output logic               halted
);

    fetch_state_t    state_reg, state_next;
    logic [15:0]     ir_out_reg, ir_out_next;
    logic            ir_valid_reg, ir_valid_next;
    logic [PC_W-1:0] pc_out_reg, pc_out_next;
    logic            flush_reg, flush_next;
    logic            halted_reg, halted_next;
    logic [15:0]     vec_hi_reg, vec_hi_next;

    logic            pc_load, pc_inc;
    logic [PC_W-1:0] pc_load_val;
    logic [PC_W-1:0] pc;

    pc_reg #(.PC_W(PC_W)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .inc      (pc_inc),
        .load_val (pc_load_val),
        .pc       (pc)
    );

    always_comb begin
        case (state_reg)
            BOOT_HI: imem_addr = IMEM_AW'(RESET_VEC_ADDR_HI);
            BOOT_LO: imem_addr = IMEM_AW'(RESET_VEC_ADDR_LO);
            default: imem_addr = IMEM_AW'(pc);
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        ir_out_next   = ir_out_reg;
        ir_valid_next = ir_valid_reg;
        pc_out_next   = pc_out_reg;
        flush_next    = 1'b0;
        halted_next   = halted_reg;
        vec_hi_next   = vec_hi_reg;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;
        pc_load_val   = jump_target;

        case (state_reg)
            BOOT_HI: begin
                vec_hi_next = imem_data;
                state_next  = BOOT_LO;
            end
            BOOT_LO: begin
                // Vector is 32 bits in memory; keep only the low PC_W bits.
                pc_load     = 1'b1;
                pc_load_val = PC_W'({vec_hi_reg, imem_data});
                state_next  = RUN;
            end
            RUN: begin
                if (jump_bit) begin
                    pc_load       = 1'b1;
                    ir_out_next   = NOP_WORD;
                    ir_valid_next = 1'b0;
                    flush_next    = 1'b1;
                end else if (!stall) begin
                    ir_out_next   = imem_data;
                    ir_valid_next = 1'b1;
                    pc_out_next   = pc;
                    pc_inc        = 1'b1;
                    if (imem_data[15:11] == HLT_OPCODE) begin
                        state_next  = HALTED;
                        halted_next = 1'b1;
                    end
                end
            end
            HALTED: begin
                ir_out_next   = NOP_WORD;
                ir_valid_next = 1'b0;
                if (jump_bit) begin
                    pc_load     = 1'b1;
                    flush_next  = 1'b1;
                    halted_next = 1'b0;
                    state_next  = RUN;
                end
            end
            default: state_next = BOOT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= BOOT_HI;
            ir_out_reg   <= NOP_WORD;
            ir_valid_reg <= 1'b0;
            pc_out_reg   <= '0;
            flush_reg    <= 1'b0;
            halted_reg   <= 1'b0;
            vec_hi_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            ir_out_reg   <= ir_out_next;
            ir_valid_reg <= ir_valid_next;
            pc_out_reg   <= pc_out_next;
            flush_reg    <= flush_next;
            halted_reg   <= halted_next;
            vec_hi_reg   <= vec_hi_next;
        end
    end

    assign ir_out   = ir_out_reg;
    assign ir_valid = ir_valid_reg;
    assign pc_out   = pc_out_reg;
    assign flush    = flush_reg;
    assign halted   = halted_reg;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage feeding the immediate/bubble detector that follows it.
- Owns the PC and boots from a reset vector held in instruction memory.
- Each cycle presents one 16-bit word from instruction memory, registered, with a valid flag.
- Handles stall, jump redirect with flush, and a HALT freeze.

Parameters:
- PC_W, 32, PC width in words; reset vector is PC_W bits, stored as two 16-bit words. Legal: 17..32.
- IMEM_AW, 20, instruction-memory word-address width. PC is truncated to IMEM_AW bits on imem_addr.
- HLT_OPCODE, 5'b00001, value of instr[15:11] that halts fetch.
- NOP_WORD, 16'h0000, word driven on ir_out whenever ir_valid=0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  IMEM_AW  word address to instruction memory; combinational from state/PC.
- imem_data  in  16  memory word at imem_addr, valid in the same cycle (asynchronous read).
- stall  in  1  hold PC and ir_out; no new word issued.
- jump_bit  in  1  redirect request from execute.
- jump_target  in  PC_W  redirect address, sampled when jump_bit=1.
- ir_out  out  16  registered instruction word to the detector.
- ir_valid  out  1  ir_out holds a real fetched word.
- pc_out  out  PC_W  address of the word currently on ir_out.
- flush  out  1  one-cycle pulse after a redirect; detector drops any pending immediate.
- halted  out  1  fetch frozen by HLT.

Behaviour:
- Async reset (rst_n=0): state=BOOT_HI, pc=0, ir_out=NOP_WORD, ir_valid=0, pc_out=0, flush=0, halted=0, vec_hi=0. Reset overrides everything, including mid-boot.
- Upstream contract: no stall or jump_bit during BOOT_HI or BOOT_LO. The boot sequence never asserts either signal itself.
- BOOT_HI:
  - imem_addr=0.
  - Latch vec_hi = imem_data on the clock edge.
  - Next state BOOT_LO.
- BOOT_LO:
  - imem_addr=1.
  - pc <= {vec_hi, imem_data} truncated to PC_W, keeping the low PC_W bits.
  - Next state RUN.
  - ir_valid stays 0 throughout boot.
- RUN, one word per cycle, with imem_addr=pc[IMEM_AW-1:0]. Priority: jump > stall > normal.
  - jump_bit=1:
    - pc <= jump_target.
    - ir_out <= NOP_WORD, ir_valid <= 0, flush <= 1.
    - Stall is ignored this cycle.
    - The word at the old pc is discarded.
  - stall=1, no jump: pc, ir_out, ir_valid and pc_out all hold. flush <= 0.
  - Normal:
    - ir_out <= imem_data, ir_valid <= 1, pc_out <= pc.
    - pc <= pc+1, wrapping modulo 2^PC_W.
    - flush <= 0.
    - Immediates are ordinary words; the detector classifies them, not this block.
  - HLT: if imem_data[15:11]==HLT_OPCODE on a normal issue, the HLT word is still issued (ir_valid=1). Next state HALTED, halted <= 1, pc <= pc+1.
- HALTED:
  - ir_out <= NOP_WORD, ir_valid <= 0, pc frozen, halted=1.
  - stall has no effect.
  - jump_bit=1 exits: pc <= jump_target, flush <= 1, halted <= 0, state RUN.
- flush is high for exactly one cycle per accepted jump. Back-to-back jumps give flush high on consecutive cycles, and the last target wins.
- Latency: imem_data is sampled at the edge and appears on ir_out one cycle later. After rst_n deasserts, the first valid word appears on the 3rd rising edge.

Decomposition:
- Shared package fetch_pkg:
  - state enum {BOOT_HI, BOOT_LO, RUN, HALTED}.
  - HLT_OPCODE default, NOP_WORD, RESET_VEC_ADDR_HI=0, RESET_VEC_ADDR_LO=1.
- One sub-module, pc_reg: PC register with load/hold/increment and async active-low reset.
- The FSM and output register stay in fetch_unit.

Test Plan:
- Boot:
  - Stimulus: mem[0]=16'h0000, mem[1]=16'h0010, mem[16]=16'h1234; release reset.
  - Response: edge 3 gives ir_out=16'h1234, ir_valid=1, pc_out=16; next imem_addr=17.
- Stall:
  - Stimulus: stall=1 for 3 cycles while pc=20.
  - Response: ir_out/pc_out unchanged; imem_addr stays 20; after release, word at 20 issues next edge.
- Jump with concurrent stall:
  - Stimulus: jump_bit=1, stall=1, jump_target=100 at pc=25.
  - Response: next cycle flush=1, ir_valid=0, ir_out=16'h0000; following cycle ir_out=mem[100], pc_out=100.
- Halt:
  - Stimulus: mem[30]={5'b00001,11'h0} fetched.
  - Response: HLT issued with ir_valid=1, then halted=1, ir_valid=0 indefinitely.
  - Stimulus: jump_bit=1, target=40.
  - Response: flush=1, then mem[40] issued.
- Wrap:
  - Stimulus: PC_W=17, pc=17'h1FFFF.
  - Response: next pc=0; pc_out shows 17'h1FFFF then 0.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during RUN and during BOOT_LO.
  - Response: outputs reach reset values immediately without a clock; boot restarts from address 0.
